// File: rtl/uart_rx_fifo_if.sv
// AXI4-Stream channel carrying received UART characters and per-word error flags.
interface uart_rx_fifo_if #(
   parameter int unsigned DATA_WIDTH = 9
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic [1:0]            tuser;

   modport master (output tdata, output tvalid, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tuser, output tready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Configurable UART receiver with 3-sample majority voting and break detection,
// buffering characters in an RX FIFO presented as an AXI4-Stream master.
module uart_rx_fifo #(
   parameter int unsigned DATA_WIDTH  = 9,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rxd,
   uart_rx_fifo_if.master               m_axis,
   output logic                         busy,
   output logic                         overrun_error,
   output logic                         frame_error,
   output logic                         parity_error,
   output logic                         break_detect,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   input  logic [15:0]                  prescale,
   input  logic [3:0]                   cfg_data_bits,
   input  logic [1:0]                   cfg_parity,
   input  logic                         cfg_stop_bits
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned WW = DATA_WIDTH + 2;
   localparam logic [3:0]  MAX_BITS = 4'(DATA_WIDTH);
   localparam logic [3:0]  MIN_BITS = 4'd5;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_rxd_prev;
   logic                   w_rxd;

   logic [15:0]            r_prescale;
   logic [3:0]             r_nbits;
   logic                   r_par_en, r_par_odd, r_two_stop;
   logic [15:0]            r_pcnt;
   logic [2:0]             r_tick;
   logic [3:0]             r_bit;
   logic                   r_stop_idx;
   logic                   r_s3, r_s4;
   logic [DATA_WIDTH-1:0]  r_shift;
   logic                   r_par_acc, r_perr, r_ferr, r_all_zero;

   logic                   w_tick_end, w_dec, w_bit_end, w_maj;
   logic                   w_start, w_fin, w_brk, w_ferr_fin;
   logic [3:0]             w_nbits;

   logic                   r_push_req;
   logic [WW-1:0]          r_push_word;
   logic                   r_busy, r_ovr_p, r_ferr_p, r_perr_p, r_brk_p;

   logic [WW-1:0]          r_mem [FIFO_DEPTH];
   logic [AW-1:0]          r_wptr, r_rptr, w_rptr_nxt;
   logic [CW-1:0]          r_count, w_count_nxt;
   logic                   w_full, w_pop, w_push;
   logic [WW-1:0]          w_head_nxt;
   logic [DATA_WIDTH-1:0]  r_tdata;
   logic [1:0]             r_tuser;
   logic                   r_tvalid;

   // rxd synchroniser and edge history
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync     <= '1;
         r_rxd_prev <= 1'b1;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], rxd};
         r_rxd_prev <= w_rxd;
      end
   end
   assign w_rxd = r_sync[SYNC_STAGES-1];

   assign w_nbits    = (cfg_data_bits < MIN_BITS) ? MIN_BITS :
                       (cfg_data_bits > MAX_BITS) ? MAX_BITS : cfg_data_bits;
   assign w_tick_end = (r_pcnt == r_prescale - 16'd1);
   assign w_dec      = w_tick_end && (r_tick == 3'd5);
   assign w_bit_end  = w_tick_end && (r_tick == 3'd7);
   assign w_maj      = (r_s3 & r_s4) | (r_s3 & w_rxd) | (r_s4 & w_rxd);
   assign w_brk      = r_all_zero & ~w_maj;
   assign w_ferr_fin = r_ferr | ~w_maj;

   // tick/sub-bit timer, held at zero while waiting for a start edge
   always_ff @(posedge clk) begin
      if (rst || r_state == S_IDLE || r_state == S_WAIT_IDLE) begin
         r_pcnt <= '0;
         r_tick <= '0;
      end else if (w_tick_end) begin
         r_pcnt <= '0;
         r_tick <= r_tick + 3'd1;
      end else begin
         r_pcnt <= r_pcnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s3 <= 1'b1;
         r_s4 <= 1'b1;
      end else if (w_tick_end && r_tick == 3'd3) begin
         r_s3 <= w_rxd;
      end else if (w_tick_end && r_tick == 3'd4) begin
         r_s4 <= w_rxd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_fin       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (prescale != 16'd0 && r_rxd_prev && !w_rxd) begin
               w_state_nxt = S_START;
               w_start     = 1'b1;
            end
         end
         S_START: begin
            if (w_dec && w_maj)  w_state_nxt = S_IDLE;
            else if (w_bit_end)  w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (w_bit_end && r_bit == r_nbits - 4'd1)
               w_state_nxt = r_par_en ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            if (w_bit_end) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            // last stop bit ends the frame at its decision point
            if (w_dec && r_stop_idx == r_two_stop) begin
               w_fin       = 1'b1;
               w_state_nxt = w_brk ? S_WAIT_IDLE : S_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (w_rxd) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // frame datapath: configuration latch, shift register, error accumulation
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prescale <= '0;
         r_nbits    <= MIN_BITS;
         r_par_en   <= 1'b0;
         r_par_odd  <= 1'b0;
         r_two_stop <= 1'b0;
         r_bit      <= '0;
         r_stop_idx <= 1'b0;
         r_shift    <= '0;
         r_par_acc  <= 1'b0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         r_all_zero <= 1'b0;
      end else if (w_start) begin
         r_prescale <= prescale;
         r_nbits    <= w_nbits;
         r_par_en   <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
         r_par_odd  <= (cfg_parity == 2'b01);
         r_two_stop <= cfg_stop_bits;
         r_bit      <= '0;
         r_stop_idx <= 1'b0;
         r_shift    <= '0;
         r_par_acc  <= 1'b0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         r_all_zero <= 1'b1;
      end else begin
         if (w_dec) begin
            case (r_state)
               S_DATA: begin
                  r_shift   <= r_shift | (DATA_WIDTH'(w_maj) << r_bit);
                  r_par_acc <= r_par_acc ^ w_maj;
               end
               S_PARITY: r_perr <= ((r_par_acc ^ w_maj) != r_par_odd);
               S_STOP: begin
                  if (!w_maj) r_ferr <= 1'b1;
                  r_stop_idx <= 1'b1;
               end
               default: ;
            endcase
            if (w_maj && (r_state == S_DATA || r_state == S_PARITY || r_state == S_STOP))
               r_all_zero <= 1'b0;
         end
         if (w_bit_end && r_state == S_DATA) r_bit <= r_bit + 4'd1;
      end
   end

   // frame completion: push request and error pulses, suppressed for a break
   always_ff @(posedge clk) begin
      if (rst) begin
         r_push_req  <= 1'b0;
         r_push_word <= '0;
         r_perr_p    <= 1'b0;
         r_ferr_p    <= 1'b0;
         r_brk_p     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_push_req <= w_fin & ~w_brk;
         if (w_fin) r_push_word <= {w_ferr_fin, r_perr, r_shift};
         r_perr_p   <= w_fin & ~w_brk & r_perr;
         r_ferr_p   <= w_fin & ~w_brk & w_ferr_fin;
         r_brk_p    <= w_fin & w_brk;
         r_busy     <= (w_state_nxt != S_IDLE);
      end
   end

   assign w_full      = (r_count == CW'(FIFO_DEPTH));
   assign w_pop       = r_tvalid & m_axis.tready;
   assign w_push      = r_push_req & (~w_full | w_pop);
   assign w_rptr_nxt  = w_pop ? r_rptr + AW'(1) : r_rptr;
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
   // bypass the incoming word when it becomes the new head
   assign w_head_nxt  = (w_push && w_rptr_nxt == r_wptr) ? r_push_word : r_mem[w_rptr_nxt];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= r_push_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tuser  <= '0;
         r_ovr_p  <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         r_rptr   <= w_rptr_nxt;
         r_count  <= w_count_nxt;
         r_tvalid <= (w_count_nxt != '0);
         r_tdata  <= (w_count_nxt != '0) ? w_head_nxt[DATA_WIDTH-1:0] : '0;
         r_tuser  <= (w_count_nxt != '0) ? w_head_nxt[WW-1:DATA_WIDTH] : 2'b00;
         r_ovr_p  <= r_push_req & w_full & ~w_pop;
      end
   end

   assign m_axis.tdata  = r_tdata;
   assign m_axis.tuser  = r_tuser;
   assign m_axis.tvalid = r_tvalid;
   assign busy          = r_busy;
   assign overrun_error = r_ovr_p;
   assign frame_error   = r_ferr_p;
   assign parity_error  = r_perr_p;
   assign break_detect  = r_brk_p;
   assign fifo_count    = r_count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames in, expected AXI words queued
// at stimulus time and compared as the DUT hands them out.
module tb_uart_rx_fifo;
   localparam int unsigned DW      = 9;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned PRESC   = 4;
   localparam int unsigned BIT_CLK = PRESC * 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rxd = 1'b1;
   logic        tready = 1'b0;
   logic [15:0] prescale = 16'(PRESC);
   logic [3:0]  cfg_data_bits = 4'd8;
   logic [1:0]  cfg_parity = 2'b00;
   logic        cfg_stop_bits = 1'b0;
   logic        busy, overrun_error, frame_error, parity_error, break_detect;
   logic [$clog2(DEPTH):0] fifo_count;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned n_ovr = 0, n_frm = 0, n_par = 0, n_brk = 0;
   logic [31:0] sb[$];

   uart_rx_fifo_if #(.DATA_WIDTH(DW)) axis_if ();
   assign axis_if.tready = tready;

   uart_rx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .m_axis(axis_if),
      .busy(busy), .overrun_error(overrun_error), .frame_error(frame_error),
      .parity_error(parity_error), .break_detect(break_detect),
      .fifo_count(fifo_count), .prescale(prescale),
      .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
      .cfg_stop_bits(cfg_stop_bits)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word(input logic [1:0] u, input logic [8:0] d);
      return {21'b0, u, d};
   endfunction

   function automatic logic even_par(input logic [8:0] d, input int nb);
      logic p = 1'b0;
      for (int i = 0; i < nb; i++) p ^= d[i];
      return p;
   endfunction

   // pulse counting (high cycles) and scoreboard pop on each accepted beat
   always @(negedge clk) begin
      if (!rst) begin
         if (overrun_error) n_ovr++;
         if (frame_error)   n_frm++;
         if (parity_error)  n_par++;
         if (break_detect)  n_brk++;
         if (axis_if.tvalid && axis_if.tready) begin
            if (sb.size() == 0)
               check_eq("spurious_word", word(axis_if.tuser, axis_if.tdata), 32'hFFFF_FFFF);
            else
               check_eq("word", word(axis_if.tuser, axis_if.tdata), sb.pop_front());
         end
      end
   end

   task automatic send_bit(input logic b);
      rxd = b;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   // glitch_bit >= 0 inserts a one-tick high pulse at tick 4 of that (low) data bit
   task automatic send_frame(input logic [8:0] d, input int nb, input bit par_en,
                             input logic pbit, input int nstop, input logic stop_lvl,
                             input int glitch_bit);
      send_bit(1'b0);
      for (int i = 0; i < nb; i++) begin
         if (i == glitch_bit) begin
            rxd = 1'b0; repeat (4 * PRESC) @(negedge clk);
            rxd = 1'b1; repeat (PRESC) @(negedge clk);
            rxd = 1'b0; repeat (3 * PRESC) @(negedge clk);
         end else begin
            send_bit(d[i]);
         end
      end
      if (par_en) send_bit(pbit);
      for (int i = 0; i < nstop; i++) send_bit(stop_lvl);
      rxd = 1'b1;
      repeat (2 * BIT_CLK) @(negedge clk);
   endtask

   task automatic set_tready(input logic v);
      @(posedge clk);
      #2 tready = v;
   endtask

   task automatic wait_tvalid(input logic lvl, input int max_cyc, input string tag);
      int n = 0;
      while (axis_if.tvalid !== lvl && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, axis_if.tvalid, lvl);
   endtask

   task automatic wait_busy(input logic lvl, input int max_cyc, input string tag);
      int n = 0;
      while (busy !== lvl && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, busy, lvl);
   endtask

   task automatic check_pulses(input string tag, input int o, input int f, input int p, input int b);
      check_eq({tag, "_ovr"}, n_ovr, o);
      check_eq({tag, "_frm"}, n_frm, f);
      check_eq({tag, "_par"}, n_par, p);
      check_eq({tag, "_brk"}, n_brk, b);
   endtask

   initial begin
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_tvalid", axis_if.tvalid, 1'b0);
      check_eq("rst_count", fifo_count, 0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_tdata", axis_if.tdata, 0);
      check_eq("rst_pulses", {overrun_error, frame_error, parity_error, break_detect}, 0);

      // 8N1 0x5A held in the FIFO, busy drops at the stop decision
      sb.push_back(word(2'b00, 9'h05A));
      fork
         send_frame(9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, -1);
         begin
            repeat (BIT_CLK * 9 + 20) @(negedge clk);
            check_eq("busy_in_stop", busy, 1'b1);
            repeat (8) @(negedge clk);
            check_eq("busy_after_stop", busy, 1'b0);
         end
      join
      check_eq("count_5a", fifo_count, 1);
      check_eq("tvalid_5a", axis_if.tvalid, 1'b1);
      set_tready(1'b1);
      wait_tvalid(1'b0, 10, "drain_5a");
      check_eq("sb_5a", sb.size(), 0);
      check_pulses("8n1", 0, 0, 0, 0);

      // stop bit low on a non-zero character: frame error, word still pushed
      sb.push_back(word(2'b10, 9'h03C));
      send_frame(9'h03C, 8, 1'b0, 1'b0, 1, 1'b0, -1);
      check_eq("sb_ferr", sb.size(), 0);
      check_pulses("ferr", 0, 1, 0, 0);

      // 7E2: correct parity, then forced wrong parity bit
      cfg_data_bits = 4'd7; cfg_parity = 2'b10; cfg_stop_bits = 1'b1;
      sb.push_back(word(2'b00, 9'h041));
      send_frame(9'h041, 7, 1'b1, even_par(9'h041, 7), 2, 1'b1, -1);
      sb.push_back(word(2'b01, 9'h041));
      send_frame(9'h041, 7, 1'b1, ~even_par(9'h041, 7), 2, 1'b1, -1);
      check_eq("sb_7e2", sb.size(), 0);
      check_pulses("7e2", 0, 1, 1, 0);

      // false start then a glitched 0x00
      cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop_bits = 1'b0;
      rxd = 1'b0;
      repeat (PRESC) @(negedge clk);
      rxd = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
      check_eq("false_start_busy", busy, 1'b0);
      check_eq("false_start_count", fifo_count, 0);
      check_pulses("false_start", 0, 1, 1, 0);
      sb.push_back(word(2'b00, 9'h000));
      send_frame(9'h000, 8, 1'b0, 1'b0, 1, 1'b1, 2);
      check_eq("sb_glitch", sb.size(), 0);

      // overrun: five words into a four-entry FIFO
      set_tready(1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) sb.push_back(word(2'b00, 9'(8'h11 + i)));
         send_frame(9'(8'h11 + i), 8, 1'b0, 1'b0, 1, 1'b1, -1);
      end
      check_eq("ovr_count", fifo_count, 4);
      check_pulses("ovr", 1, 1, 1, 0);
      set_tready(1'b1);
      wait_tvalid(1'b0, 20, "ovr_drain");
      check_eq("sb_ovr", sb.size(), 0);

      // break: line low for two frame times
      rxd = 1'b0;
      repeat (BIT_CLK * 20 - 40) @(negedge clk);
      check_eq("brk_busy", busy, 1'b1);
      repeat (40) @(negedge clk);
      rxd = 1'b1;
      wait_busy(1'b0, 10, "brk_busy_release");
      check_eq("brk_count", fifo_count, 0);
      check_pulses("brk", 1, 1, 1, 1);
      repeat (BIT_CLK) @(negedge clk);
      sb.push_back(word(2'b00, 9'h033));
      send_frame(9'h033, 8, 1'b0, 1'b0, 1, 1'b1, -1);
      check_eq("sb_33", sb.size(), 0);

      // reset in the middle of a data bit with two words buffered
      set_tready(1'b0);
      send_frame(9'h021, 8, 1'b0, 1'b0, 1, 1'b1, -1);
      send_frame(9'h022, 8, 1'b0, 1'b0, 1, 1'b1, -1);
      check_eq("pre_rst_count", fifo_count, 2);
      fork
         send_frame(9'h0FE, 8, 1'b0, 1'b0, 1, 1'b1, -1);
         begin
            repeat (BIT_CLK * 4 + 10) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_eq("mid_rst_tvalid", axis_if.tvalid, 1'b0);
            check_eq("mid_rst_count", fifo_count, 0);
            check_eq("mid_rst_busy", busy, 1'b0);
            check_eq("mid_rst_pulses", {overrun_error, frame_error, parity_error, break_detect}, 0);
         end
      join
      set_tready(1'b1);
      repeat (2 * BIT_CLK) @(negedge clk);
      check_eq("post_rst_count", fifo_count, 0);
      check_eq("post_rst_tvalid", axis_if.tvalid, 1'b0);

      sb.push_back(word(2'b00, 9'h0A5));
      send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, -1);
      check_eq("sb_final", sb.size(), 0);
      check_pulses("final", 1, 1, 1, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
